// File: rtl/alu_div_pkg.sv
// Shared types and constants for the radix-2 restoring divider (alu_div).
package alu_div_pkg;

    localparam int DIV_XLEN  = 32;
    localparam int DIV_CNT_W = $clog2(DIV_XLEN);

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/alu_div_abs.sv
// Conditional two's-complement negate, used for operand magnitudes and the
// final result sign fix of alu_div.
module alu_div_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (~val + {{(W-1){1'b0}}, 1'b1}) : val;

endmodule

// File: rtl/alu_div.sv
// Sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with
// valid/ready handshakes. Optional macro ALU_DIV_EARLY_OUT_EN: finish at once when |a| < |b|.
module alu_div
    import alu_div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_div_valid,
    output logic            o_div_ready,
    input  logic [1:0]      i_div_op,
    input  logic [XLEN-1:0] i_div_a,
    input  logic [XLEN-1:0] i_div_b,
    input  logic            i_div_flush,
    output logic            o_div_valid,
    input  logic            i_div_result_ready,
    output logic [XLEN-1:0] o_div_result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

    div_state_e       state_r;
    div_op_e          op_r;
    logic [XLEN-1:0]  rem_r, quo_r, dvsr_r, result_r;
    logic [CNT_W-1:0] cnt_r;
    logic             neg_quo_r, neg_rem_r, ready_r, valid_r;

    div_op_e          req_op_s;
    logic             req_signed_s, req_rem_s, accept_s;
    logic             div_zero_s, ovf_s, early_s, special_s;
    logic [XLEN-1:0]  mag_a_s, mag_b_s, special_res_s;
    logic [XLEN:0]    shifted_s;
    logic             no_borrow_s;
    logic [XLEN-1:0]  rem_nxt_s, quo_nxt_s, fix_in_s, fixed_s;
    logic             fix_neg_s;

    assign req_op_s     = div_op_e'(i_div_op);
    assign req_signed_s = ~i_div_op[0];
    assign req_rem_s    = i_div_op[1];
    assign accept_s     = i_div_valid & ready_r & ~i_div_flush;
    assign div_zero_s   = (i_div_b == ZERO);
    assign ovf_s        = req_signed_s & (i_div_a == MIN_NEG) & (i_div_b == ALL_ONES);

    alu_div_abs #(.W(XLEN)) u_abs_a (
        .val (i_div_a),
        .neg (req_signed_s & i_div_a[XLEN-1]),
        .res (mag_a_s)
    );

    alu_div_abs #(.W(XLEN)) u_abs_b (
        .val (i_div_b),
        .neg (req_signed_s & i_div_b[XLEN-1]),
        .res (mag_b_s)
    );

`ifdef ALU_DIV_EARLY_OUT_EN
    assign early_s = ~div_zero_s & (mag_a_s < mag_b_s);
`else
    assign early_s = 1'b0;
`endif

    assign special_s = div_zero_s | ovf_s | early_s;

    // Results that are known at accept time and bypass the iteration.
    always_comb begin
        special_res_s = ZERO;
        if (div_zero_s) begin
            special_res_s = req_rem_s ? i_div_a : ALL_ONES;
        end else if (ovf_s) begin
            special_res_s = req_rem_s ? ZERO : MIN_NEG;
        end else begin
            special_res_s = req_rem_s ? i_div_a : ZERO;
        end
    end

    // One restoring step: shift {rem, quo} left, trial-subtract the divisor.
    always_comb begin
        shifted_s   = {rem_r, quo_r[XLEN-1]};
        no_borrow_s = (shifted_s >= {1'b0, dvsr_r});
        quo_nxt_s   = {quo_r[XLEN-2:0], no_borrow_s};
        if (no_borrow_s) begin
            rem_nxt_s = shifted_s[XLEN-1:0] - dvsr_r;
        end else begin
            rem_nxt_s = shifted_s[XLEN-1:0];
        end
    end

    assign fix_in_s  = op_r[1] ? rem_nxt_s : quo_nxt_s;
    assign fix_neg_s = op_r[1] ? neg_rem_r : neg_quo_r;

    alu_div_abs #(.W(XLEN)) u_abs_fix (
        .val (fix_in_s),
        .neg (fix_neg_s),
        .res (fixed_s)
    );

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r   <= S_IDLE;
            op_r      <= OP_DIV;
            rem_r     <= ZERO;
            quo_r     <= ZERO;
            dvsr_r    <= ZERO;
            result_r  <= ZERO;
            cnt_r     <= {CNT_W{1'b0}};
            neg_quo_r <= 1'b0;
            neg_rem_r <= 1'b0;
            ready_r   <= 1'b1;
            valid_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        op_r      <= req_op_s;
                        neg_quo_r <= req_signed_s & (i_div_a[XLEN-1] ^ i_div_b[XLEN-1]);
                        neg_rem_r <= req_signed_s & i_div_a[XLEN-1];
                        rem_r     <= ZERO;
                        quo_r     <= mag_a_s;
                        dvsr_r    <= mag_b_s;
                        cnt_r     <= CNT_W'(XLEN - 1);
                        ready_r   <= 1'b0;
                        if (special_s) begin
                            state_r  <= S_DONE;
                            valid_r  <= 1'b1;
                            result_r <= special_res_s;
                        end else begin
                            state_r <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (i_div_flush) begin
                        state_r <= S_IDLE;
                        ready_r <= 1'b1;
                    end else begin
                        rem_r <= rem_nxt_s;
                        quo_r <= quo_nxt_s;
                        cnt_r <= cnt_r - CNT_W'(1);
                        if (cnt_r == {CNT_W{1'b0}}) begin
                            state_r  <= S_DONE;
                            valid_r  <= 1'b1;
                            result_r <= fixed_s;
                        end
                    end
                end
                S_DONE: begin
                    // Flush and result handshake both retire the result.
                    if (i_div_flush || i_div_result_ready) begin
                        state_r <= S_IDLE;
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign o_div_ready  = ready_r;
    assign o_div_valid  = valid_r;
    assign o_div_result = result_r;

endmodule

// File: tb/tb_alu_div.sv
// Self-checking bench for alu_div: directed table, corner sequences and
// random operands against an arithmetic reference model.
module tb_alu_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_valid, div_ready, div_flush, res_valid, res_ready;
    logic [1:0]  div_op;
    logic [31:0] div_a, div_b, div_result;

    int n_vec = 0;
    int n_err = 0;

    alu_div dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_div_valid        (div_valid),
        .o_div_ready        (div_ready),
        .i_div_op           (div_op),
        .i_div_a            (div_a),
        .i_div_b            (div_b),
        .i_div_flush        (div_flush),
        .o_div_valid        (res_valid),
        .i_div_result_ready (res_ready),
        .o_div_result       (div_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // RISC-V M-extension semantics in plain arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : 32'h8000_0000;
        case (op)
            2'b00:   return $unsigned(sa / sb);
            2'b01:   return a / b;
            2'b10:   return $unsigned(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb;
        ma = (!op[0] && a[31]) ? -a : a;
        mb = (!op[0] && b[31]) ? -b : b;
        if (b == 32'h0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef ALU_DIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`else
        if (ma < mb) return 33;
`endif
        return 33;
    endfunction

    // Issue one request at the current negedge, wait for the result, retire it.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string name);
        int lat;
        chk({name, "/ready"}, {31'h0, div_ready}, 32'h1);
        div_valid = 1'b1;
        div_op = op;
        div_a = a;
        div_b = b;
        @(negedge clk);
        div_valid = 1'b0;
        div_a = $urandom;
        div_b = $urandom;
        div_op = 2'($urandom);
        lat = 1;
        while (!res_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "/latency"}, lat, exp_lat);
        chk({name, "/result"}, div_result, exp);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({name, "/retire"}, {30'h0, res_valid, div_ready}, 32'h1);
    endtask

    vec_t vecs[$];

    initial begin
        int cyc;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic        seen;

        rst = 1'b1;
        div_valid = 1'b0;
        div_flush = 1'b0;
        res_ready = 1'b0;
        div_op = 2'b00;
        div_a = 32'h0;
        div_b = 32'h0;
        #1;
        chk("reset_outputs", {div_result[29:0], res_valid, div_ready}, 32'h1);
        chk("reset_result", div_result, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        vecs.push_back('{2'b00, 32'd100, 32'd7, 32'd14, 33, "div_100_7"});
        vecs.push_back('{2'b10, 32'd100, 32'd7, 32'd2, 33, "rem_100_7"});
        vecs.push_back('{2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2"});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2"});
        vecs.push_back('{2'b01, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33, "divu_m7_2"});
        vecs.push_back('{2'b01, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1, "divu_by0"});
        vecs.push_back('{2'b11, 32'h1234, 32'h0, 32'h1234, 1, "remu_by0"});
        vecs.push_back('{2'b00, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1, "div_by0"});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 1, "rem_by0"});
        vecs.push_back('{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf"});
        vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, "rem_ovf"});
        vecs.push_back('{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33, "divu_no_ovf"});
        vecs.push_back('{2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_m2"});
        vecs.push_back('{2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, "rem_7_m2"});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, "divu_max_1"});
`ifdef ALU_DIV_EARLY_OUT_EN
        vecs.push_back('{2'b01, 32'd3, 32'd9, 32'd0, 1, "divu_3_9"});
        vecs.push_back('{2'b11, 32'd3, 32'd9, 32'd3, 1, "remu_3_9"});
        vecs.push_back('{2'b10, 32'hFFFF_FFFD, 32'd9, 32'hFFFF_FFFD, 1, "rem_m3_9"});
`else
        vecs.push_back('{2'b01, 32'd3, 32'd9, 32'd0, 33, "divu_3_9"});
        vecs.push_back('{2'b11, 32'd3, 32'd9, 32'd3, 33, "remu_3_9"});
        vecs.push_back('{2'b10, 32'hFFFF_FFFD, 32'd9, 32'hFFFF_FFFD, 33, "rem_m3_9"});
`endif

        foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);

        // Backpressure: result held stable while the consumer stalls.
        div_valid = 1'b1; div_op = 2'b00; div_a = 32'd100; div_b = 32'd7;
        @(negedge clk);
        div_valid = 1'b0; div_a = 32'd5; div_b = 32'd5;
        cyc = 1;
        while (!res_valid && cyc < 100) begin @(negedge clk); cyc++; end
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", {31'h0, res_valid}, 32'h1);
            chk("bp_result", div_result, 32'd14);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("bp_retire", {30'h0, res_valid, div_ready}, 32'h1);

        // Flush at CALC cycle 10: idle at cycle 11, no result ever.
        div_valid = 1'b1; div_op = 2'b01; div_a = 32'd1000; div_b = 32'd3;
        @(negedge clk);
        div_valid = 1'b0;
        for (int k = 1; k < 10; k++) @(negedge clk);
        div_flush = 1'b1;
        @(negedge clk);
        div_flush = 1'b0;
        chk("flush_calc_ready", {30'h0, res_valid, div_ready}, 32'h1);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        chk("flush_calc_no_result", {31'h0, seen}, 32'h0);

        // Flush in IDLE blocks acceptance.
        div_valid = 1'b1; div_flush = 1'b1; div_op = 2'b01; div_a = 32'd9; div_b = 32'd0;
        @(negedge clk);
        div_valid = 1'b0; div_flush = 1'b0;
        chk("flush_idle_block", {30'h0, res_valid, div_ready}, 32'h1);

        // Flush in DONE discards the pending result.
        div_valid = 1'b1; div_op = 2'b01; div_a = 32'd9; div_b = 32'd0;
        @(negedge clk);
        div_valid = 1'b0;
        chk("flush_done_pre", {30'h0, res_valid, div_ready}, 32'h2);
        div_flush = 1'b1;
        @(negedge clk);
        div_flush = 1'b0;
        chk("flush_done_post", {30'h0, res_valid, div_ready}, 32'h1);

        // Asynchronous reset in the middle of CALC.
        div_valid = 1'b1; div_op = 2'b01; div_a = 32'd100; div_b = 32'd7;
        @(negedge clk);
        div_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_flags", {30'h0, res_valid, div_ready}, 32'h1);
        chk("async_rst_result", div_result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(2'b01, 32'd9, 32'd3, 32'd3, 33, "divu_9_3_after_rst");

        // Random operands against the reference model.
        for (int n = 0; n < 150; n++) begin
            rop = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom >> $urandom_range(8, 28);
            endcase
            if ($urandom_range(0, 15) == 0) ra = 32'h8000_0000;
            run_op(rop, ra, rb, ref_div(rop, ra, rb), ref_lat(rop, ra, rb), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
